// File: rtl/pipe_regfile_if.sv
// Decode/writeback bundle for the PIPE register file: decode request,
// operand response, stall handshake and the retiring-instruction write port.
interface pipe_regfile_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned REG_AW = 4
);
   logic [3:0]        icode_i;
   logic [REG_AW-1:0] rA_i;
   logic [REG_AW-1:0] rB_i;
   logic              dec_valid_i;
   logic              dec_ready_o;
   logic [REG_AW-1:0] srcA_o;
   logic [REG_AW-1:0] srcB_o;
   logic [REG_AW-1:0] dstE_o;
   logic [REG_AW-1:0] dstM_o;
   logic [DATA_W-1:0] valA_o;
   logic [DATA_W-1:0] valB_o;
   logic              wb_valid_i;
   logic [REG_AW-1:0] wb_dstE_i;
   logic [REG_AW-1:0] wb_dstM_i;
   logic              wb_cnd_i;
   logic [DATA_W-1:0] wb_valE_i;
   logic [DATA_W-1:0] wb_valM_i;
   logic              err_o;

   modport master (
      output icode_i, rA_i, rB_i, dec_valid_i,
      output wb_valid_i, wb_dstE_i, wb_dstM_i, wb_cnd_i, wb_valE_i, wb_valM_i,
      input  dec_ready_o, srcA_o, srcB_o, dstE_o, dstM_o, valA_o, valB_o, err_o
   );

   modport slave (
      input  icode_i, rA_i, rB_i, dec_valid_i,
      input  wb_valid_i, wb_dstE_i, wb_dstM_i, wb_cnd_i, wb_valE_i, wb_valM_i,
      output dec_ready_o, srcA_o, srcB_o, dstE_o, dstM_o, valA_o, valB_o, err_o
   );
endinterface

// File: rtl/pipe_regfile.sv
// Y86-64 PIPE decode-stage register file: operand decode, write-through bypass
// from writeback, and per-register pending-write scoreboard driving the stall.
module pipe_regfile #(
   parameter int unsigned       DATA_W     = 64,
   parameter int unsigned       REG_AW     = 4,
   parameter int unsigned       NREGS      = 15,
   parameter int unsigned       PEND_W     = 2,
   parameter logic [DATA_W-1:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
   input  logic          clk_i,
   input  logic          rst_i,
   pipe_regfile_if.slave bus
);

   typedef enum logic [3:0] {
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   localparam logic [REG_AW-1:0] NREG = '1;
   localparam logic [REG_AW-1:0] RSP  = REG_AW'(4);
   localparam logic [PEND_W-1:0] PMAX = '1;

   logic [DATA_W-1:0] regs [NREGS];
   logic [PEND_W-1:0] pend [NREGS];
   logic              err_q;

   logic [REG_AW-1:0] src_a, src_b, dst_e, dst_m;
   logic [DATA_W-1:0] arr_a, arr_b;
   logic [NREGS-1:0]  ret, inc, busy, full;
   logic              stall, issue, we_e, we_m;

   always_comb begin
      src_a = NREG;
      src_b = NREG;
      dst_e = NREG;
      dst_m = NREG;
      case (bus.icode_i)
         I_RRMOVQ: begin src_a = bus.rA_i; dst_e = bus.rB_i; end
         I_IRMOVQ: dst_e = bus.rB_i;
         I_RMMOVQ: begin src_a = bus.rA_i; src_b = bus.rB_i; end
         I_MRMOVQ: begin src_b = bus.rB_i; dst_m = bus.rA_i; end
         I_OPQ:    begin src_a = bus.rA_i; src_b = bus.rB_i; dst_e = bus.rB_i; end
         I_CALL:   begin src_b = RSP; dst_e = RSP; end
         I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
         I_PUSHQ:  begin src_a = bus.rA_i; src_b = RSP; dst_e = RSP; end
         I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = bus.rA_i; end
         default:  ;
      endcase
   end

   function automatic logic [DATA_W-1:0] read_port(
      input logic [REG_AW-1:0] src,
      input logic [DATA_W-1:0] arr,
      input logic              wb_valid,
      input logic              wb_cnd,
      input logic [REG_AW-1:0] wb_dst_e,
      input logic [REG_AW-1:0] wb_dst_m,
      input logic [DATA_W-1:0] val_e,
      input logic [DATA_W-1:0] val_m
   );
      if (src == NREG)                              return '0;
      else if (wb_valid && wb_dst_m == src)           return val_m;
      else if (wb_valid && wb_cnd && wb_dst_e == src) return val_e;
      else                                          return arr;
   endfunction

   // Retire/busy/full are per-register so a shared dstE==dstM tag counts once.
   always_comb begin
      arr_a = '0;
      arr_b = '0;
      ret   = '0;
      busy  = '0;
      full  = '0;
      stall = 1'b0;
      for (int unsigned r = 0; r < NREGS; r++) begin
         if (src_a == REG_AW'(r)) arr_a = regs[r];
         if (src_b == REG_AW'(r)) arr_b = regs[r];
         ret[r]  = bus.wb_valid_i &&
                   (bus.wb_dstE_i == REG_AW'(r) || bus.wb_dstM_i == REG_AW'(r));
         busy[r] = pend[r] > {{(PEND_W-1){1'b0}}, ret[r]};
         full[r] = (pend[r] == PMAX) && !ret[r];
         if ((src_a == REG_AW'(r) || src_b == REG_AW'(r)) && busy[r]) stall = 1'b1;
         if ((dst_e == REG_AW'(r) || dst_m == REG_AW'(r)) && full[r]) stall = 1'b1;
      end
   end

   assign issue = bus.dec_valid_i && !stall;
   assign we_e  = bus.wb_valid_i && bus.wb_cnd_i && (bus.wb_dstE_i != NREG);
   assign we_m  = bus.wb_valid_i && (bus.wb_dstM_i != NREG);

   always_comb begin
      inc = '0;
      for (int unsigned r = 0; r < NREGS; r++)
         inc[r] = issue && (dst_e == REG_AW'(r) || dst_m == REG_AW'(r));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            regs[r] <= (r == 4) ? STACK_INIT : '0;
            pend[r] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            // M is written last so it wins when both ports hit one register.
            if (we_e && bus.wb_dstE_i == REG_AW'(r)) regs[r] <= bus.wb_valE_i;
            if (we_m && bus.wb_dstM_i == REG_AW'(r)) regs[r] <= bus.wb_valM_i;
            if (inc[r] && !ret[r]) begin
               if (pend[r] != PMAX) pend[r] <= pend[r] + 1'b1;
            end else if (ret[r] && !inc[r]) begin
               if (pend[r] == '0) err_q   <= 1'b1;
               else               pend[r] <= pend[r] - 1'b1;
            end
         end
      end
   end

   assign bus.srcA_o      = src_a;
   assign bus.srcB_o      = src_b;
   assign bus.dstE_o      = dst_e;
   assign bus.dstM_o      = dst_m;
   assign bus.dec_ready_o = !stall;
   assign bus.err_o       = err_q;
   assign bus.valA_o = read_port(src_a, arr_a, bus.wb_valid_i, bus.wb_cnd_i,
                                 bus.wb_dstE_i, bus.wb_dstM_i, bus.wb_valE_i, bus.wb_valM_i);
   assign bus.valB_o = read_port(src_b, arr_b, bus.wb_valid_i, bus.wb_cnd_i,
                                 bus.wb_dstE_i, bus.wb_dstM_i, bus.wb_valE_i, bus.wb_valM_i);

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_regfile;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   pipe_regfile_if #(.DATA_W(64), .REG_AW(4)) bus ();

   pipe_regfile #(
      .DATA_W(64), .REG_AW(4), .NREGS(15), .PEND_W(2),
      .STACK_INIT(64'h0000_0000_0000_0200)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic        rdy;
      logic [3:0]  sa, sb, de, dm;
      logic [63:0] va, vb;
      logic        er;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic cmp(input string nm, input string fld,
                      input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.name, "dec_ready", {63'd0, bus.dec_ready_o}, {63'd0, e.rdy});
         cmp(e.name, "srcA",      {60'd0, bus.srcA_o},      {60'd0, e.sa});
         cmp(e.name, "srcB",      {60'd0, bus.srcB_o},      {60'd0, e.sb});
         cmp(e.name, "dstE",      {60'd0, bus.dstE_o},      {60'd0, e.de});
         cmp(e.name, "dstM",      {60'd0, bus.dstM_o},      {60'd0, e.dm});
         cmp(e.name, "valA",      bus.valA_o,               e.va);
         cmp(e.name, "valB",      bus.valB_o,               e.vb);
         cmp(e.name, "err",       {63'd0, bus.err_o},       {63'd0, e.er});
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic dec(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                      input logic v);
      bus.icode_i     = ic;
      bus.rA_i        = a;
      bus.rB_i        = b;
      bus.dec_valid_i = v;
   endtask

   task automatic wb(input logic v, input logic [3:0] e, input logic [3:0] m,
                     input logic c, input logic [63:0] ve, input logic [63:0] vm);
      bus.wb_valid_i = v;
      bus.wb_dstE_i  = e;
      bus.wb_dstM_i  = m;
      bus.wb_cnd_i   = c;
      bus.wb_valE_i  = ve;
      bus.wb_valM_i  = vm;
   endtask

   task automatic wb_idle();
      wb(1'b0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic expect_v(input string nm, input logic rdy,
                           input logic [3:0] sa, input logic [3:0] sb,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic [63:0] va, input logic [63:0] vb,
                           input logic er);
      exp_t e;
      e.name = nm; e.rdy = rdy; e.sa = sa; e.sb = sb; e.de = de; e.dm = dm;
      e.va = va; e.vb = vb; e.er = er;
      q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      dec(4'h0, 4'hF, 4'hF, 1'b0);
      wb_idle();

      step(); dec(4'hB, 4'h3, 4'hF, 1'b0);
      expect_v("reset_popq", 1, 4'h4, 4'h4, 4'h4, 4'h3, 64'h200, 64'h200, 0);
      step(); rst_i = 1'b1;

      dec(4'h3, 4'hF, 4'h2, 1'b1);
      expect_v("irmovq_r2", 1, 4'hF, 4'hF, 4'h2, 4'hF, 0, 0, 0);
      step(); dec(4'h6, 4'h2, 4'h1, 1'b1);
      expect_v("opq_stall", 0, 4'h2, 4'h1, 4'h1, 4'hF, 0, 0, 0);
      step(); wb(1, 4'h2, 4'hF, 1, 64'h55, 0);
      expect_v("opq_bypass", 1, 4'h2, 4'h1, 4'h1, 4'hF, 64'h55, 0, 0);
      step(); wb_idle(); dec(4'h2, 4'h2, 4'h3, 1'b0);
      expect_v("r2_array", 1, 4'h2, 4'hF, 4'h3, 4'hF, 64'h55, 0, 0);
      step(); dec(4'h0, 4'hF, 4'hF, 1'b0); wb(1, 4'h1, 4'hF, 1, 64'h11, 0);
      expect_v("retire_r1", 1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 0);

      step(); wb_idle(); dec(4'hB, 4'h4, 4'hF, 1'b1);
      expect_v("popq_rsp", 1, 4'h4, 4'h4, 4'h4, 4'h4, 64'h200, 64'h200, 0);
      step(); dec(4'hB, 4'h4, 4'hF, 1'b0); wb(1, 4'h4, 4'h4, 1, 64'h1F8, 64'h99);
      expect_v("m_over_e_byp", 1, 4'h4, 4'h4, 4'h4, 4'h4, 64'h99, 64'h99, 0);
      step(); wb_idle(); dec(4'h4, 4'h4, 4'h1, 1'b0);
      expect_v("r4_r1_array", 1, 4'h4, 4'h1, 4'hF, 4'hF, 64'h99, 64'h11, 0);

      step(); dec(4'h2, 4'h3, 4'h5, 1'b1);
      expect_v("cmov_issue", 1, 4'h3, 4'hF, 4'h5, 4'hF, 0, 0, 0);
      step(); dec(4'h2, 4'h5, 4'h3, 1'b0);
      expect_v("r5_stall", 0, 4'h5, 4'hF, 4'h3, 4'hF, 0, 0, 0);
      step(); wb(1, 4'h5, 4'hF, 0, 64'h77, 0);
      expect_v("cmov_nt_wb", 1, 4'h5, 4'hF, 4'h3, 4'hF, 0, 0, 0);
      step(); wb_idle();
      expect_v("r5_unchanged", 1, 4'h5, 4'hF, 4'h3, 4'hF, 0, 0, 0);

      for (int i = 0; i < 3; i++) begin
         step(); dec(4'h3, 4'hF, 4'h6, 1'b1);
         expect_v("irmovq_r6", 1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 0);
      end
      step();
      expect_v("r6_full", 0, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 0);
      step(); wb(1, 4'h6, 4'hF, 1, 64'h66, 0);
      expect_v("r6_full_ret", 1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 0);
      step(); dec(4'h2, 4'h6, 4'hF, 1'b0); wb(1, 4'h6, 4'hF, 1, 64'h67, 0);
      expect_v("r6_drain3", 0, 4'h6, 4'hF, 4'hF, 4'hF, 64'h67, 0, 0);
      step(); wb(1, 4'h6, 4'hF, 1, 64'h68, 0);
      expect_v("r6_drain2", 0, 4'h6, 4'hF, 4'hF, 4'hF, 64'h68, 0, 0);
      step(); wb(1, 4'h6, 4'hF, 1, 64'h69, 0);
      expect_v("r6_drain1", 1, 4'h6, 4'hF, 4'hF, 4'hF, 64'h69, 0, 0);

      step(); dec(4'h0, 4'hF, 4'hF, 1'b0); wb(1, 4'h7, 4'hF, 1, 64'h70, 0);
      expect_v("underflow_wb", 1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 0);
      step(); wb_idle();
      expect_v("err_set", 1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 1);
      step(); dec(4'h2, 4'h6, 4'hF, 1'b0);
      expect_v("err_sticky", 1, 4'h6, 4'hF, 4'hF, 4'hF, 64'h69, 0, 1);

      step(); rst_i = 1'b0; dec(4'hB, 4'h3, 4'hF, 1'b0);
      expect_v("reset_again", 1, 4'h4, 4'h4, 4'h4, 4'h3, 64'h200, 64'h200, 0);
      step(); rst_i = 1'b1; dec(4'h4, 4'h6, 4'h1, 1'b0);
      expect_v("post_reset", 1, 4'h6, 4'h1, 4'hF, 4'hF, 0, 0, 0);

      step();
      for (int i = 0; i < 5 && q.size() > 0; i++) step();
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised decode-stage register file with scoreboard for the pipelined Y86-64 core. It decodes `srcA`/`srcB`/`dstE`/`dstM` from `icode`/`rA`/`rB`, reads two operands with write-through bypass from the writeback stage, and tracks per-register pending writes with saturating counters. It drives a decode-stall handshake, replacing the single-cycle SEQ register file in the PIPE design.

## Interface
- `DATA_W`, 64, register data width
- `REG_AW`, 4, register address width; all-ones (`4'hF`) is NREG
- `NREGS`, 15, number of architectural registers (0..NREGS-1)
- `PEND_W`, 2, pending-counter width; max in-flight writers per register = 2^PEND_W-1
- `STACK_INIT`, 64'h0000_0000_0000_0200, reset value of `%rsp` (reg 4)

- `clk_i` in 1: the single clock; all state updates on the rising edge
- `rst_i` in 1: reset, asynchronous, active-low
- `icode_i` in 4: instruction code in decode
- `rA_i`, `rB_i` in REG_AW: register specifiers
- `dec_valid_i` in 1: decode holds a valid instruction
- `dec_ready_o` out 1: no hazard; issue occurs when `dec_valid_i && dec_ready_o`
- `srcA_o`, `srcB_o`, `dstE_o`, `dstM_o` out REG_AW: decoded register IDs
- `valA_o`, `valB_o` out DATA_W: operand values
- `wb_valid_i` in 1: an instruction retires this cycle
- `wb_dstE_i`, `wb_dstM_i` in REG_AW: dst tags claimed at issue
- `wb_cnd_i` in 1: E write enable (0 for a not-taken cmov)
- `wb_valE_i`, `wb_valM_i` in DATA_W: writeback data
- `err_o` out 1: sticky scoreboard underflow flag

## Operation
- Decode (combinational):
  - srcA = rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ; RSP for POPQ, RET; otherwise NREG.
  - srcB = rB for OPQ, RMMOVQ, MRMOVQ; RSP for PUSHQ, POPQ, CALL, RET; otherwise NREG.
  - dstE = rB for RRMOVQ, IRMOVQ, OPQ; RSP for PUSHQ, POPQ, CALL, RET; otherwise NREG.
  - dstM = rA for MRMOVQ, POPQ; otherwise NREG.
  - Codes: RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, CALL=8, RET=9, PUSHQ=A, POPQ=B; RSP=4.
- Read, evaluated per port in priority order:
  1. src==NREG → 0.
  2. `wb_valid_i` && wb_dstM==src → `wb_valM_i`.
  3. `wb_valid_i` && `wb_cnd_i` && wb_dstE==src → `wb_valE_i`.
  4. Otherwise the array value.
- Write on posedge:
  - E when `wb_valid_i && wb_cnd_i && wb_dstE_i!=NREG`.
  - M when `wb_valid_i && wb_dstM_i!=NREG`.
  - Same address on both ports → M value is stored.
  - Addresses ≥NREGS other than NREG are ignored.
- Pending counters `pend[r]`:
  - +1 per distinct non-NREG dst on issue; dstE==dstM counts once.
  - −1 per distinct non-NREG wb tag on `wb_valid_i`, regardless of `wb_cnd_i`.
  - Increment and decrement of the same register in the same cycle → unchanged.
  - A decrement at 0 holds the counter at 0 and sets `err_o`.
- Hazard: `dec_ready_o` = 0 when either condition holds:
  - Any non-NREG src has effective pend ≥1, where effective pend = pend − (retiring this cycle ? 1 : 0). A source with pend==1 retiring this cycle is bypassed and does not stall.
  - Any non-NREG dst has pend at the maximum value and is not retiring.
- No issue occurs while `dec_valid_i`=0. `dec_ready_o` is still computed.

## Timing
- Decode, `valA_o`/`valB_o`, and `dec_ready_o` are combinational: zero-cycle latency from `icode`/`rA`/`rB`/wb inputs.
- Register writes and counter updates take effect at the rising edge. A read in the next cycle sees the array value.
- Reset (`rst_i`=0, asynchronous):
  - All registers are 0, except reg 4 = `STACK_INIT`.
  - All `pend` counters are 0 and `err_o` is 0.
  - Consequently `dec_ready_o`=1 and `valA_o`/`valB_o` reflect the reset array.
- Reset mid-operation discards all pending claims. Writebacks arriving after reset release only trigger `err_o` if their counter is 0.
- Deassertion is synchronised externally; the block requires no extra cycles after release.

## Test plan
- Reset with STACK_INIT=0x200, icode=POPQ(B), rA=3 → srcA=srcB=4, valA=valB=0x200, dstE=4, dstM=3, dec_ready=1.
- Issue IRMOVQ rB=2. Next cycle OPQ rA=2 rB=1 → dec_ready=0. Then wb_valid, dstE=2, cnd=1, valE=0x55 → same-cycle dec_ready=1, valA=0x55. The following cycle reads 0x55 from the array.
- wb with dstE=dstM=4, valE=0x1F8, valM=0x99 → reg4=0x99 after the edge, and bypass shows 0x99 in the same cycle.
- cmov with wb_cnd=0, dstE=5, valE=0x77 → reg5 unchanged, pend[5] decremented to 0, dec_ready restores.
- Issue three IRMOVQ rB=6 with no wb (PEND_W=2) → pend[6]=3; the fourth is stalled (dec_ready=0) until one wb on 6.
- wb_valid with dstE=7 while pend[7]=0 → err_o=1 and stays 1; rst_i low → err_o=0.
